// File: rtl/gpu_host_arb_pkg.sv
// Shared types for the GPU RAM host-port arbiter.
//   ADDR_W / DATA_W : default host address and data widths
//   req_id_t        : which requester owns an access (A = Z80 bus, B = blitter)
//   rd_tag_t        : one slot of the in-flight read tracker
package gpu_host_arb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/host_read_tag_pipe.sv
// Fixed-length shift register that follows each issued read through the RAM
// read latency, so the returning byte can be steered to its owner.
//   clk, rst : clock, asynchronous active-high reset (clears every slot)
//   tag_i    : tag loaded into slot 0 at each edge
//   tag_o    : oldest slot; valid when ram_rdata belongs to a read
module host_read_tag_pipe
  import gpu_host_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t pipe_q [DEPTH];

  // NOTE: every slot is reset, not just the data path, because a stale valid
  // bit left over from before reset would fabricate a read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every slot sample its neighbour's
      // old value, which is what makes this a shift register and not a wire.
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/gpu_host_port_arbiter.sv
// Arbitrates the single GPU RAM host port between requester A (Z80 bus) and
// requester B (blitter). The winner is registered onto ram_addr/ram_wdata/
// ram_wena; reads are tracked through a tag pipeline and each returned byte
// is delivered to the requester that issued it.
//   a_req_i/a_wr_i/a_addr_i/a_wdata_i : A request (held until a_ack_o)
//   a_ack_o                           : combinational accept for A
//   a_rd_valid_o/a_rd_data_o          : one-cycle read return to A
//   b_*                               : same set for B
//   ram_addr_o/ram_wdata_o/ram_wena_o : registered RAM host command
//   ram_rdata_i                       : RAM read data, READ_LATENCY after addr
module gpu_host_port_arbiter
  import gpu_host_arb_pkg::*;
#(
  parameter int ADDR_W       = gpu_host_arb_pkg::ADDR_W,
  parameter int DATA_W       = gpu_host_arb_pkg::DATA_W,
  parameter int READ_LATENCY = 2,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_i,
  input  logic              a_wr_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_ack_o,
  output logic              a_rd_valid_o,
  output logic [DATA_W-1:0] a_rd_data_o,
  input  logic              b_req_i,
  input  logic              b_wr_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_ack_o,
  output logic              b_rd_valid_o,
  output logic [DATA_W-1:0] b_rd_data_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_wena_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  req_id_t           last_grant_q, last_grant_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q,  ram_wdata_d;
  logic              ram_wena_q,   ram_wena_d;
  logic              a_rd_valid_q, a_rd_valid_d;
  logic              b_rd_valid_q, b_rd_valid_d;
  logic [DATA_W-1:0] a_rd_data_q,  a_rd_data_d;
  logic [DATA_W-1:0] b_rd_data_q,  b_rd_data_d;

  logic    tie_to_b;
  logic    grant_a, grant_b;
  rd_tag_t tag_in, tag_out;

  // NOTE: every signal gets a default at the top of the block, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    // On a tie: round-robin picks whoever did not win last; priority mode
    // picks A unless B has been passed over STARVE_LIMIT times in a row.
    if (ARB_MODE == 0) tie_to_b = (last_grant_q == REQ_A);
    else               tie_to_b = (starve_cnt_q == STARVE_MAX);

    // Acks are suppressed while rst is high so all outputs read 0 in reset.
    grant_a = !rst && a_req_i && (!b_req_i || !tie_to_b);
    grant_b = !rst && b_req_i && (!a_req_i || tie_to_b);

    last_grant_d = last_grant_q;
    if (grant_a)      last_grant_d = REQ_A;
    else if (grant_b) last_grant_d = REQ_B;

    starve_cnt_d = '0;
    if (ARB_MODE == 1 && b_req_i && !grant_b) begin
      starve_cnt_d = starve_cnt_q;
      if (grant_a && starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Address and data hold when idle; only the write strobe drops.
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_wena_d   = 1'b0;
    tag_in.valid = 1'b0;
    tag_in.id    = REQ_A;
    if (grant_a) begin
      ram_addr_d   = a_addr_i;
      ram_wdata_d  = a_wdata_i;
      ram_wena_d   = a_wr_i;
      tag_in.valid = !a_wr_i;
      tag_in.id    = REQ_A;
    end else if (grant_b) begin
      ram_addr_d   = b_addr_i;
      ram_wdata_d  = b_wdata_i;
      ram_wena_d   = b_wr_i;
      tag_in.valid = !b_wr_i;
      tag_in.id    = REQ_B;
    end

    // The oldest tag lines up with ram_rdata; capture it for its owner.
    a_rd_valid_d = tag_out.valid && (tag_out.id == REQ_A);
    b_rd_valid_d = tag_out.valid && (tag_out.id == REQ_B);
    a_rd_data_d  = a_rd_valid_d ? ram_rdata_i : a_rd_data_q;
    b_rd_data_d  = b_rd_valid_d ? ram_rdata_i : b_rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= REQ_B;
      starve_cnt_q <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_wena_q   <= 1'b0;
      a_rd_valid_q <= 1'b0;
      b_rd_valid_q <= 1'b0;
      a_rd_data_q  <= '0;
      b_rd_data_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_wena_q   <= ram_wena_d;
      a_rd_valid_q <= a_rd_valid_d;
      b_rd_valid_q <= b_rd_valid_d;
      a_rd_data_q  <= a_rd_data_d;
      b_rd_data_q  <= b_rd_data_d;
    end
  end

  // Slot 0 is visible with ram_addr; the last slot with ram_rdata.
  host_read_tag_pipe #(
    .DEPTH(READ_LATENCY + 1)
  ) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .tag_i(tag_in),
    .tag_o(tag_out)
  );

  assign a_ack_o      = grant_a;
  assign b_ack_o      = grant_b;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign ram_wena_o   = ram_wena_q;
  assign a_rd_valid_o = a_rd_valid_q;
  assign b_rd_valid_o = b_rd_valid_q;
  assign a_rd_data_o  = a_rd_data_q;
  assign b_rd_data_o  = b_rd_data_q;

endmodule

// File: doc/gpu_host_port_arbiter.md
Name: gpu_host_port_arbiter

Overview:
Shares the single 8-bit host port of the GPU RAM between two requesters: A (Z80 bus interface) and B (blitter/geometry engine). It registers the winning request onto the RAM host port. Because the RAM has a fixed read latency, it tracks in-flight reads with a tag pipeline and returns each read byte to the requester that issued it. Sits between the requesters and the host address/data/write-enable inputs of the multi-port GPU RAM.

Parameters:
ADDR_W, 20, host address width
DATA_W, 8, host data width
READ_LATENCY, 2, clk cycles from registered ram_addr to valid ram_rdata (range 1..8)
ARB_MODE, 0, 0 = round-robin; 1 = A fixed priority with starvation guard
STARVE_LIMIT, 4, ARB_MODE=1 only: consecutive A grants while B waits before B is forced (range 1..15)

Ports:
clk  in  1  system clock (125 MHz)
rst  in  1  asynchronous reset, active-high
a_req  in  1  A request valid; hold a_req/a_wr/a_addr/a_wdata until a_ack
a_wr  in  1  1 = write, 0 = read
a_addr  in  ADDR_W  A address
a_wdata  in  DATA_W  A write byte
a_ack  out  1  combinational; high = A request accepted this cycle
a_rd_valid  out  1  one-cycle pulse; a_rd_data valid
a_rd_data  out  DATA_W  read byte returned to A
b_req, b_wr, b_addr, b_wdata, b_ack, b_rd_valid, b_rd_data  same as A, for requester B
ram_addr  out  ADDR_W  to RAM host address
ram_wdata  out  DATA_W  to RAM host write data
ram_wena  out  1  to RAM host write enable; one-cycle pulse per accepted write
ram_rdata  in  DATA_W  from RAM host read data

Behaviour:
- Reset (async assert; all flops released on the next edge after deassert):
  - all outputs 0; tag pipeline cleared; last_grant = B, so A wins the first tie; starve_cnt = 0.
  - Reads in flight when rst asserts are discarded: no rd_valid is produced for them.
- Grant (combinational, cycle T). At most one of a_ack/b_ack is high.
  - Only one requester active: grant it.
  - Both active, ARB_MODE=0: grant the requester not equal to last_grant.
  - Both active, ARB_MODE=1: grant A, unless starve_cnt == STARVE_LIMIT, then grant B.
- starve_cnt (ARB_MODE=1):
  - increments, saturating, on each A grant while b_req=1;
  - clears on any B grant or whenever b_req=0.
- last_grant updates on every grant.
- Issue (registered at end of cycle T, visible in T+1):
  - ram_addr <= granted addr; ram_wdata <= granted wdata; ram_wena <= granted wr.
  - No grant: ram_wena <= 0; ram_addr and ram_wdata hold their values.
- Throughput: one access per clk. Back-to-back grants to the same requester are allowed; a requester may present a new request in the cycle after its ack.
- Read tag pipeline:
  - Depth READ_LATENCY+1 entries of {valid, id}.
  - Entry 0 is loaded at issue with valid = (granted && !wr) and id = granted requester.
  - When the last entry is valid, ram_rdata is captured into x_rd_data and x_rd_valid pulses for exactly one cycle.
  - Read response latency: x_rd_valid is high in cycle T+READ_LATENCY+2 (cycle T+4 by default).
  - Responses to one requester return in issue order.
  - A write never produces rd_valid.
- rd_data holds its last value when rd_valid=0.
- Simultaneous events:
  - A read issue and a response retirement in the same cycle are independent.
  - The same requester may have up to READ_LATENCY+1 reads outstanding.
- Address and data widths pass through unchanged. No address-window check; the RAM applies its own window.

Decomposition:
- Package gpu_host_arb_pkg:
  - localparams ADDR_W=20, DATA_W=8;
  - typedef enum logic {REQ_A=1'b0, REQ_B=1'b1} req_id_t;
  - typedef struct packed {logic valid; req_id_t id;} rd_tag_t.
- Sub-module host_read_tag_pipe: parameterised shift register of rd_tag_t, depth READ_LATENCY+1, with async reset clearing all valids; the arbiter instantiates one.

Test Plan:
1. Reset, then A alone writes addr 0x00123 data 0x5A → a_ack=1 in T; ram_addr=0x00123, ram_wdata=0x5A, ram_wena=1 in T+1 only; no a_rd_valid.
2. A reads 0x00010 with the RAM model returning 0xC3 (RL=2) → a_rd_valid pulses in T+4 with a_rd_data=0xC3; b_rd_valid stays 0.
3. ARB_MODE=0, a_req and b_req both held high for 6 cycles (reads) → acks alternate A,B,A,B,A,B starting with A; the six rd_valid pulses alternate A/B in the same order.
4. ARB_MODE=1, STARVE_LIMIT=4, both held high → grant sequence A,A,A,A,B,A,A,A,A,B; starve_cnt clears after each B grant.
5. A issues three back-to-back reads (0x1,0x2,0x3 → 0x11,0x22,0x33) → a_rd_valid high three consecutive cycles with data 0x11,0x22,0x33 in order.
6. Issue two reads, assert rst one cycle later → all outputs 0 immediately; no rd_valid after rst deasserts; the first request after reset wins as A on a tie.
